// File: rtl/pd_dw_lte_pwr.sv
// Per-symbol I^2+Q^2 accumulator; one 48-bit write per completed symbol to the peak-hold stage.
// Latency: last sample accepted at cycle t -> o_we at t+4, single-cycle strobe.
// Backpressure: none; accepts one sample per cycle at full rate, gaps via i_iq_vld.
module pd_dw_lte_pwr #(
    parameter int SYM_PER_FRAME = 140
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_iq_vld,
    input  logic [15:0] i_iq_i,
    input  logic [15:0] i_iq_q,
    input  logic        i_sym_start,
    input  logic        i_frame_start,
    input  logic [2:0]  i_ant_sel,
    input  logic [15:0] i_sym_len,
    output logic        o_we,
    output logic [10:0] o_addr,
    output logic [47:0] o_din,
    output logic [15:0] o_short_cnt
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] ACC      = 1'b1;
    localparam logic [7:0] LAST_IDX = 8'(SYM_PER_FRAME - 1);

    logic [0:0]  cnt_state;
    logic [7:0]  sym_idx;
    logic [15:0] len_r;
    logic [15:0] samp_cnt;
    logic [10:0] cur_addr;

    logic        sym_go;
    logic [7:0]  idx_nxt;
    logic [15:0] cnt_nxt;
    logic        t_vld;
    logic        t_first;
    logic        t_last;
    logic [10:0] t_addr;

    always_comb begin
        sym_go  = i_iq_vld & i_sym_start;
        idx_nxt = (i_frame_start || sym_idx == LAST_IDX) ? 8'd0 : sym_idx + 8'd1;
        cnt_nxt = samp_cnt + 16'd1;
        t_vld   = 1'b0;
        t_first = 1'b0;
        t_last  = 1'b0;
        t_addr  = cur_addr;
        if (sym_go) begin
            // zero-length symbols still consume an index but never tag a sample
            t_vld   = (i_sym_len != 16'd0);
            t_first = 1'b1;
            t_last  = (i_sym_len == 16'd1);
            t_addr  = {i_ant_sel, idx_nxt};
        end else if (cnt_state == ACC && i_iq_vld) begin
            t_vld  = 1'b1;
            t_last = (cnt_nxt == len_r);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_state   <= IDLE;
            sym_idx     <= LAST_IDX;
            len_r       <= 16'd0;
            samp_cnt    <= 16'd0;
            cur_addr    <= 11'd0;
            o_short_cnt <= 16'd0;
        end else if (sym_go) begin
            sym_idx   <= idx_nxt;
            len_r     <= i_sym_len;
            samp_cnt  <= 16'd1;
            cur_addr  <= t_addr;
            cnt_state <= (i_sym_len > 16'd1) ? ACC : IDLE;
            if (cnt_state == ACC && o_short_cnt != 16'hFFFF)
                o_short_cnt <= o_short_cnt + 16'd1;
        end else if (cnt_state == ACC && i_iq_vld) begin
            samp_cnt <= cnt_nxt;
            if (t_last)
                cnt_state <= IDLE;
        end
    end

    logic signed [31:0] ext_i;
    logic signed [31:0] ext_q;
    logic [30:0]        sq_i_c;
    logic [30:0]        sq_q_c;

    assign ext_i  = 32'(signed'(i_iq_i));
    assign ext_q  = 32'(signed'(i_iq_q));
    assign sq_i_c = 31'(ext_i * ext_i);
    assign sq_q_c = 31'(ext_q * ext_q);

    logic        s1_vld, s1_first, s1_last;
    logic [10:0] s1_addr;
    logic [30:0] s1_sq_i, s1_sq_q;
    logic        s2_vld, s2_first, s2_last;
    logic [10:0] s2_addr;
    logic [31:0] s2_p;
    logic        s3_last;
    logic [10:0] s3_addr;
    logic [47:0] acc;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= 11'd0;
            s1_sq_i  <= 31'd0;
            s1_sq_q  <= 31'd0;
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_addr  <= 11'd0;
            s2_p     <= 32'd0;
            s3_last  <= 1'b0;
            s3_addr  <= 11'd0;
            acc      <= 48'd0;
            o_we     <= 1'b0;
            o_addr   <= 11'd0;
            o_din    <= 48'd0;
        end else begin
            s1_vld   <= t_vld;
            s1_first <= t_first;
            s1_last  <= t_last;
            s1_addr  <= t_addr;
            s1_sq_i  <= sq_i_c;
            s1_sq_q  <= sq_q_c;

            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_addr  <= s1_addr;
            s2_p     <= {1'b0, s1_sq_i} + {1'b0, s1_sq_q};

            // a first tag reloads the sum, discarding any aborted symbol's residue
            if (s2_vld)
                acc <= s2_first ? {16'd0, s2_p} : acc + {16'd0, s2_p};
            s3_last <= s2_vld & s2_last;
            s3_addr <= s2_addr;

            o_we <= s3_last;
            if (s3_last) begin
                o_addr <= s3_addr;
                o_din  <= acc;
            end
        end
    end

endmodule
